// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point constants and state type for the XOR network datapath.
// Used by the MAC neuron, the rescale/saturate stage and the sigmoid stage.
package nn_fixed_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAC_BITS = 8;

  localparam int Q_ONE = 256;
  localparam int Q_MAX = 32767;
  localparam int Q_MIN = -32768;

  typedef enum logic {
    ACCUM,
    HOLD
  } state_e;

endpackage

// File: rtl/q_rescale_sat.sv
// Combinational Q24.16 accumulator + Q8.8 bias -> saturated Q8.8 result.
// The shift is arithmetic, so fractional bits are truncated toward -inf.
module q_rescale_sat #(
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [DATA_W-1:0] i_bias,
  output logic [DATA_W-1:0] o_sum
);

  import nn_fixed_pkg::*;

  localparam logic [DATA_W-1:0] SatPos = DATA_W'(Q_MAX);
  localparam logic [DATA_W-1:0] SatNeg = DATA_W'(Q_MIN);

  logic signed [ACC_W-1:0] w_shift;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_s;
  logic                    w_fits;

  assign w_shift    = $signed(i_acc) >>> FRAC_BITS;
  assign w_bias_ext = {{(ACC_W - DATA_W){i_bias[DATA_W-1]}}, i_bias};
  assign w_s        = w_shift + w_bias_ext;

  // In range when every bit above the result sign bit matches it.
  assign w_fits = (w_s[ACC_W-1:DATA_W-1] == '0) || (w_s[ACC_W-1:DATA_W-1] == '1);

  always_comb begin
    o_sum = w_s[DATA_W-1:0];
    if (!w_fits) begin
      o_sum = w_s[ACC_W-1] ? SatNeg : SatPos;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Sequential MAC neuron: accumulates x*w beats at full precision, adds bias,
// rescales and saturates to a Q8.8 pre-activation held until consumed.
module neuron_mac #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned MAX_LEN   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_w,
  input  logic [DATA_W-1:0] in_bias,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_err
);

  import nn_fixed_pkg::*;

  localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned PROD_W = 2 * DATA_W;

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [ACC_W-1:0]          r_acc;
  logic [CNT_W-1:0]          r_count;
  logic                      r_first;
  logic [DATA_W-1:0]         r_bias;
  logic                      r_err;
  logic [DATA_W-1:0]         r_sum;

  logic                      w_xfer;
  logic                      w_hit_max;
  logic                      w_term;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic signed [PROD_W-1:0]  w_prod;
  logic [ACC_W-1:0]          w_prod_ext;
  logic [ACC_W-1:0]          w_acc_nxt;
  logic [DATA_W-1:0]         w_bias_eff;
  logic [DATA_W-1:0]         w_sum;

  assign w_xfer     = in_valid && in_ready;
  assign w_cnt_nxt  = r_count + 1'b1;
  assign w_hit_max  = (w_cnt_nxt == CNT_W'(MAX_LEN));
  assign w_term     = w_xfer && (in_last || w_hit_max);

  assign w_prod     = $signed(in_x) * $signed(in_w);
  assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_acc_nxt  = (r_first ? '0 : r_acc) + w_prod_ext;

  // The terminating beat may also be the first, so its bias is taken live.
  assign w_bias_eff = r_first ? in_bias : r_bias;

  q_rescale_sat #(
    .ACC_W     (ACC_W),
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_rescale (
    .i_acc  (w_acc_nxt),
    .i_bias (w_bias_eff),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ACCUM: if (w_term) w_state_nxt = HOLD;
      HOLD:  if (out_ready) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      ACCUM:   in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_first <= 1'b1;
      r_bias  <= '0;
      r_err   <= 1'b0;
      r_sum   <= '0;
    end else begin
      if (w_xfer) begin
        r_acc <= w_acc_nxt;
        if (r_first) begin
          r_bias <= in_bias;
        end
        if (w_term) begin
          r_first <= 1'b1;
          r_count <= '0;
          r_sum   <= w_sum;
          r_err   <= !in_last;
        end else begin
          r_first <= 1'b0;
          r_count <= w_cnt_nxt;
        end
      end
      if (out_valid && out_ready) begin
        r_err <= 1'b0;
      end
    end
  end

  assign out_sum = r_sum;
  assign out_err = r_err;

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Sequential multiply-accumulate neuron core for the XOR network datapath. It accepts a stream of (input, weight) pairs in Q8.8 fixed point and accumulates their products at full precision. It then adds a bias, rescales and saturates the sum to a signed 16-bit Q8.8 pre-activation. That value drives the sigmoid lookup stage directly downstream, whose input must be signed Q8.8 with the binary point between bits 7 and 8.

## Interface
- DATA_W, 16, width of x, w, bias and result (signed Q8.8)
- FRAC_BITS, 8, fractional bits of all Q-format operands
- ACC_W, 40, accumulator width (signed, Q24.16)
- MAX_LEN, 16, maximum beats per vector before forced termination
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  core can accept a beat
- in_x  in  DATA_W  signed Q8.8 activation
- in_w  in  DATA_W  signed Q8.8 weight
- in_bias  in  DATA_W  signed Q8.8 bias, sampled on first beat of a vector only
- in_last  in  1  marks final beat of a vector
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  DATA_W  signed Q8.8 saturated pre-activation
- out_err  out  1  vector was force-terminated at MAX_LEN, qualified by out_valid

## Operation
- FSM states are ACCUM and HOLD. Reset enters ACCUM with acc=0, count=0, first=1.
- **ACCUM**
  - in_ready=1.
  - Beat transfer occurs on in_valid&&in_ready.
  - Each transfer does acc <= (first ? 0 : acc) + sext(in_x*in_w), where the product is a full 32-bit signed Q16.16 value.
  - On a first beat, bias_r <= in_bias and first <= 0.
  - count increments on every transfer.
  - Termination occurs on a transfer with in_last=1, or on the transfer that makes count==MAX_LEN. Forced termination without in_last sets err_r=1.
  - On termination: result computed, go to HOLD, first<=1, count<=0.
- **Result arithmetic**
  - s = (acc_final >>> FRAC_BITS) + sext(bias_r), computed in ACC_W bits. The shift is arithmetic, so truncation is toward −inf.
  - out_sum = clamp(s, −32768, 32767).
  - The result is registered, and out_sum changes only on entry to HOLD.
- **HOLD**
  - in_ready=0, out_valid=1. out_sum and out_err are held stable until out_ready.
  - On out_valid&&out_ready: go to ACCUM and clear err_r.
- **Single-beat vector:** a beat with in_last=1 on the first beat gives out_sum = sat((x*w)>>>8 + bias).
- **Reset mid-vector or mid-HOLD:** partial accumulation is discarded and all outputs return to reset values immediately.
- No bypass exists. A new vector cannot begin in the same cycle a result is consumed.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_err=0.
- Throughput is one beat per cycle in ACCUM.
- Latency: out_valid rises on the clock edge after the terminating beat transfers.
- After out_valid&&out_ready at edge k, in_ready=1 from edge k onward. Each vector therefore costs one bubble cycle.
- in_bias is ignored on non-first beats.
- in_* signals are don't-care when no transfer occurs.

## Structure
- Package nn_fixed_pkg holds:
  - DATA_W, FRAC_BITS
  - Q_ONE=256
  - Q_MAX=32767, Q_MIN=−32768
  - the state enum {ACCUM, HOLD}
- This package is shared with the sigmoid stage and the top level.
- Sub-module q_rescale_sat is combinational: ACC_W-bit accumulator plus bias in, arithmetic shift by FRAC_BITS, saturated DATA_W out. It is reused by the output layer.
- neuron_mac contains the FSM, accumulator, counters and output registers.

## Test plan
- **Two-input sum with bias:** beats (x=256,w=128), (x=256,w=128,last), bias=−64 → out_sum=192 one cycle after last; out_err=0.
- **Positive saturation:** two beats x=32767, w=32767 → out_sum=32767. Negative variant x=−32768, w=32767 → out_sum=−32768.
- **Truncation sign:** single beat x=1, w=1, bias=0 → 0. Single beat x=−1, w=1 → −1 (0xFFFF).
- **Backpressure:** hold out_ready=0 for 5 cycles → out_valid, out_sum and out_err stable and in_ready=0 throughout. Assert out_ready → in_ready=1 from the next cycle, and a following vector accumulates from zero with a fresh bias.
- **Forced termination:** MAX_LEN beats with in_last=0, all x=256, w=256 → out_sum=4096, out_err=1. The next vector reports out_err=0.
- **Reset mid-vector:** assert rst_n=0 after 3 of 4 beats → outputs go to reset values asynchronously. A full vector after release computes its result with no residue from the aborted vector.
